// File: rtl/ofdm_frame_scheduler.sv
// OFDM frame scheduler: gates a sample stream into bursts of fixed-length frames
// separated by gaps, starting a programmable offset after a sync trigger.
module ofdm_frame_scheduler #(
  parameter int unsigned SR_BASE = 130,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic             trigger,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OFFSET = 2'd1,
    S_FRAME  = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LEN_RST = CNT_W'(64);
  localparam logic [CNT_W-1:0] GAP_RST = CNT_W'(16);
  localparam logic [CNT_W-1:0] OFF_RST = CNT_W'(0);
  localparam logic [CNT_W-1:0] MAX_RST = CNT_W'(1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Live settings (bus-writable) and per-burst shadows
  logic [CNT_W-1:0] frame_len_q, gap_len_q, offset_q, max_frames_q;
  logic [CNT_W-1:0] frame_len_s_q, gap_len_s_q, offset_s_q, max_frames_s_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Effective view of the current beat: a qualifying trigger beat already
  // belongs to the burst it starts, using the live settings as its shadows.
  logic             trig_ok_c;
  logic             trig_acc_c;
  logic             hs_c;
  logic             last_c;
  state_e           st_c;
  logic [CNT_W-1:0] len_c, gap_c, off_c, max_c, cnt_c, fcnt_c;

  logic             unused_set_data;
  assign unused_set_data = ^set_data;

  // Settings register writes; the reserved slot and foreign addresses are ignored
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      frame_len_q  <= LEN_RST;
      gap_len_q    <= GAP_RST;
      offset_q     <= OFF_RST;
      max_frames_q <= MAX_RST;
    end else if (set_stb) begin
      if (set_addr == 8'(SR_BASE))     frame_len_q  <= CNT_W'(set_data);
      if (set_addr == 8'(SR_BASE + 1)) gap_len_q    <= CNT_W'(set_data);
      if (set_addr == 8'(SR_BASE + 2)) offset_q     <= CNT_W'(set_data);
      if (set_addr == 8'(SR_BASE + 3)) max_frames_q <= CNT_W'(set_data);
    end
  end

  // Beat classification and combinational stream steering
  always_comb begin
    trig_ok_c = (state_q == S_IDLE) && trigger && i_tvalid &&
                (frame_len_q != '0) && (max_frames_q != '0);
    if (trig_ok_c) begin
      st_c   = (offset_q == '0) ? S_FRAME : S_OFFSET;
      len_c  = frame_len_q;
      gap_c  = gap_len_q;
      off_c  = offset_q;
      max_c  = max_frames_q;
      cnt_c  = '0;
      fcnt_c = '0;
    end else begin
      st_c   = state_q;
      len_c  = frame_len_s_q;
      gap_c  = gap_len_s_q;
      off_c  = offset_s_q;
      max_c  = max_frames_s_q;
      cnt_c  = cnt_q;
      fcnt_c = frame_cnt_q;
    end
    last_c     = (cnt_c == len_c - ONE);
    i_tready   = (st_c == S_FRAME) ? o_tready : 1'b1;
    o_tvalid   = (st_c == S_FRAME) && i_tvalid;
    o_tlast    = (st_c == S_FRAME) && last_c;
    o_tdata    = i_tdata;
    hs_c       = i_tvalid && i_tready;
    trig_acc_c = trig_ok_c && hs_c;
  end

  // Next-state: counters advance only on handshaken beats
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (hs_c) begin
      state_d     = st_c;
      cnt_d       = cnt_c;
      frame_cnt_d = fcnt_c;
      case (st_c)
        S_OFFSET: begin
          if (cnt_c == off_c - ONE) begin
            state_d = S_FRAME;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_c + ONE;
          end
        end
        S_FRAME: begin
          if (last_c) begin
            frame_cnt_d = fcnt_c + ONE;
            cnt_d       = '0;
            if (fcnt_c == max_c - ONE) state_d = S_IDLE;
            else if (gap_c != '0)      state_d = S_GAP;
            else                       state_d = S_FRAME;
          end else begin
            cnt_d = cnt_c + ONE;
          end
        end
        S_GAP: begin
          if (cnt_c == gap_c - ONE) begin
            state_d = S_FRAME;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_c + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters and shadow capture on an accepted trigger
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      frame_cnt_q    <= '0;
      frame_len_s_q  <= LEN_RST;
      gap_len_s_q    <= GAP_RST;
      offset_s_q     <= OFF_RST;
      max_frames_s_q <= MAX_RST;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (trig_acc_c) begin
        frame_len_s_q  <= frame_len_q;
        gap_len_s_q    <= gap_len_q;
        offset_s_q     <= offset_q;
        max_frames_s_q <= max_frames_q;
      end
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule
